// File: rtl/motor_drive_if.sv
// Command and H-bridge signal bundle between the car controller side and motor_drive.
// The master drives the command; the slave (motor_drive) drives the bridge pins.
interface motor_drive_if;
    logic [3:0] ctrl_signals;
    logic [3:0] motor_in;
    logic       en_a;
    logic       en_b;
    logic [1:0] dead_active;

    modport master (output ctrl_signals, input motor_in, en_a, en_b, dead_active);
    modport slave  (input ctrl_signals, output motor_in, en_a, en_b, dead_active);
endinterface

// File: rtl/motor_drive.sv
// Dual H-bridge driver: synchronised, glitch-filtered command feeding two independent
// motor FSMs with soft-start PWM ramp and coast dead-time on direction reversal.
module motor_drive #(
    parameter int PWM_BITS      = 8,
    parameter int MAX_DUTY      = 200,
    parameter int FILTER_CYCLES = 16,
    parameter int DEAD_CYCLES   = 1000
) (
    input  logic         clk,
    input  logic         reset,
    motor_drive_if.slave bus
);
    localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [FW-1:0]       FILT_LAST = FW'(FILTER_CYCLES - 1);
    localparam logic [DW-1:0]       DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = PWM_BITS'(MAX_DUTY);

    typedef enum logic [2:0] {
        ST_COAST,
        ST_BRAKE,
        ST_FWD,
        ST_REV,
        ST_DEAD
    } state_t;

    logic [3:0]          sync_meta_reg;
    logic [3:0]          sync_reg;
    logic [3:0]          cand_reg;
    logic [3:0]          cmd_reg;
    logic [FW-1:0]       filt_cnt_reg;
    logic [FW-1:0]       filt_cnt_next;
    logic                filt_stable;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic                pwm_wrap;

    assign pwm_wrap = &pwm_cnt_reg;

    // Counter saturates at FILT_LAST so a long-held command keeps being re-accepted harmlessly.
    always_comb begin
        filt_stable   = (sync_reg == cand_reg);
        filt_cnt_next = '0;
        if (filt_stable) begin
            filt_cnt_next = (filt_cnt_reg == FILT_LAST) ? filt_cnt_reg : filt_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta_reg <= '0;
            sync_reg      <= '0;
            cand_reg      <= '0;
            cmd_reg       <= '0;
            filt_cnt_reg  <= '0;
            pwm_cnt_reg   <= '0;
        end else begin
            sync_meta_reg <= bus.ctrl_signals;
            sync_reg      <= sync_meta_reg;
            cand_reg      <= sync_reg;
            filt_cnt_reg  <= filt_cnt_next;
            if (filt_stable && (filt_cnt_next == FILT_LAST)) begin
                cmd_reg <= cand_reg;
            end
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
        end
    end

    logic [3:0] motor_in_w;
    logic [1:0] en_w;
    logic [1:0] dead_w;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_motor
            state_t              state_reg, state_next;
            logic [DW-1:0]       dead_cnt_reg, dead_cnt_next;
            logic [PWM_BITS-1:0] duty_reg, duty_next;
            logic                en_reg, en_next;
            logic [1:0]          pair;

            assign pair = cmd_reg[2*gi +: 2];

            always_comb begin
                state_next    = state_reg;
                dead_cnt_next = '0;
                if (pair == 2'b00) begin
                    state_next = ST_COAST;
                end else if (pair == 2'b11) begin
                    state_next = ST_BRAKE;
                end else begin
                    case (state_reg)
                        ST_FWD: if (pair == 2'b01) begin
                            state_next    = ST_DEAD;
                            dead_cnt_next = DEAD_LAST;
                        end
                        ST_REV: if (pair == 2'b10) begin
                            state_next    = ST_DEAD;
                            dead_cnt_next = DEAD_LAST;
                        end
                        // Exit direction follows the command at expiry, not the one that started DEAD.
                        ST_DEAD: begin
                            if (dead_cnt_reg == '0) begin
                                state_next = (pair == 2'b10) ? ST_FWD : ST_REV;
                            end else begin
                                dead_cnt_next = dead_cnt_reg - 1'b1;
                            end
                        end
                        default: state_next = (pair == 2'b10) ? ST_FWD : ST_REV;
                    endcase
                end

                duty_next = '0;
                if (((state_reg == ST_FWD) || (state_reg == ST_REV)) && (state_next == state_reg)) begin
                    duty_next = (pwm_wrap && (duty_reg < DUTY_MAX)) ? duty_reg + 1'b1 : duty_reg;
                end

                case (state_reg)
                    ST_BRAKE:       en_next = 1'b1;
                    ST_FWD, ST_REV: en_next = (pwm_cnt_reg < duty_reg);
                    default:        en_next = 1'b0;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg    <= ST_COAST;
                    dead_cnt_reg <= '0;
                    duty_reg     <= '0;
                    en_reg       <= 1'b0;
                end else begin
                    state_reg    <= state_next;
                    dead_cnt_reg <= dead_cnt_next;
                    duty_reg     <= duty_next;
                    en_reg       <= en_next;
                end
            end

            assign motor_in_w[2*gi +: 2] = (state_reg == ST_FWD)   ? 2'b10 :
                                           (state_reg == ST_REV)   ? 2'b01 :
                                           (state_reg == ST_BRAKE) ? 2'b11 : 2'b00;
            assign en_w[gi]   = en_reg;
            assign dead_w[gi] = (state_reg == ST_DEAD);
        end
    endgenerate

    assign bus.motor_in    = motor_in_w;
    assign bus.en_a        = en_w[1];
    assign bus.en_b        = en_w[0];
    assign bus.dead_active = dead_w;
endmodule

// File: tb/tb_motor_drive.sv
// Bench for motor_drive: directed scenarios plus random command streams, checked every
// cycle against a behavioural model built from the command-window and motor-mode rules.
module tb_motor_drive;
    localparam int PWM_BITS      = 4;
    localparam int MAX_DUTY      = 12;
    localparam int FILTER_CYCLES = 4;
    localparam int DEAD_CYCLES   = 20;
    localparam int PERIOD        = 1 << PWM_BITS;
    localparam int M_COAST = 0, M_BRAKE = 1, M_RUN = 2, M_DEAD = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    motor_drive_if bus();

    motor_drive #(
        .PWM_BITS(PWM_BITS), .MAX_DUTY(MAX_DUTY),
        .FILTER_CYCLES(FILTER_CYCLES), .DEAD_CYCLES(DEAD_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] obs, exp_v;

    // Behavioural model: cmd is the newest value that filled a whole window of FILTER_CYCLES
    // samples taken two cycles late; each motor is a mode plus direction, duty and dead time.
    logic [3:0] hist[$];
    logic [3:0] m_cmd;
    int         m_mode[2];
    logic [1:0] m_dir[2];
    int         m_dead[2];
    int         m_duty[2];
    bit         m_en[2];
    int         m_pwm;

    task automatic model_reset();
        hist.delete();
        repeat (FILTER_CYCLES + 2) hist.push_back(4'b0000);
        m_cmd = 4'b0000;
        m_pwm = 0;
        for (int m = 0; m < 2; m++) begin
            m_mode[m] = M_COAST; m_dir[m] = 2'b00; m_dead[m] = 0; m_duty[m] = 0; m_en[m] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [3:0] new_cmd;
        logic [1:0] pair;
        bit stable;
        hist.push_back(bus.ctrl_signals);
        hist.delete(0);
        stable = 1'b1;
        for (int i = 1; i < FILTER_CYCLES; i++) if (hist[i] != hist[0]) stable = 1'b0;
        new_cmd = stable ? hist[FILTER_CYCLES-1] : m_cmd;
        for (int m = 0; m < 2; m++) begin
            pair = m_cmd[2*m +: 2];
            m_en[m] = (m_mode[m] == M_BRAKE) || (m_mode[m] == M_RUN && m_pwm < m_duty[m]);
            if (pair == 2'b00) begin
                m_mode[m] = M_COAST; m_duty[m] = 0;
            end else if (pair == 2'b11) begin
                m_mode[m] = M_BRAKE; m_duty[m] = 0;
            end else if (m_mode[m] == M_COAST || m_mode[m] == M_BRAKE) begin
                m_mode[m] = M_RUN; m_dir[m] = pair; m_duty[m] = 0;
            end else if (m_mode[m] == M_RUN) begin
                if (pair == m_dir[m]) begin
                    if (m_pwm == PERIOD - 1 && m_duty[m] < MAX_DUTY) m_duty[m] = m_duty[m] + 1;
                end else begin
                    m_mode[m] = M_DEAD; m_dead[m] = DEAD_CYCLES - 1; m_duty[m] = 0;
                end
            end else begin
                if (m_dead[m] == 0) begin
                    m_mode[m] = M_RUN; m_dir[m] = pair; m_duty[m] = 0;
                end else begin
                    m_dead[m] = m_dead[m] - 1;
                end
            end
        end
        m_pwm = (m_pwm + 1) % PERIOD;
        m_cmd = new_cmd;
    endtask

    function automatic logic [7:0] model_outputs();
        logic [3:0] pins;
        logic [1:0] dead;
        pins = 4'b0000;
        dead = 2'b00;
        for (int m = 0; m < 2; m++) begin
            if (m_mode[m] == M_RUN) pins[2*m +: 2] = m_dir[m];
            else if (m_mode[m] == M_BRAKE) pins[2*m +: 2] = 2'b11;
            dead[m] = (m_mode[m] == M_DEAD);
        end
        return {pins, m_en[1], m_en[0], dead};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset) model_reset();
            else model_step();
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        bus.ctrl_signals = 4'b1010;
        repeat (3) @(negedge clk);
        obs = {bus.motor_in, bus.en_a, bus.en_b, bus.dead_active};
        n_checks++;
        if (obs !== 8'h00) $display("FAIL reset_outputs: got %b expected %b", obs, 8'h00);
        else n_pass++;
        exp_v = model_outputs();
        n_checks++;
        if (obs !== exp_v) $display("FAIL reset_model: got %b expected %b", obs, exp_v);
        else n_pass++;
        $display("test_reset: outputs=%b", obs);
    endtask

    task automatic test_ramp();
        int hi_a, hi_b;
        reset = 1'b0;
        bus.ctrl_signals = 4'b1010;
        for (int c = 1; c <= 7 + PERIOD * (MAX_DUTY + 2); c++) begin
            @(negedge clk);
            obs = {bus.motor_in, bus.en_a, bus.en_b, bus.dead_active};
            exp_v = model_outputs();
            n_checks++;
            if (obs !== exp_v) $display("FAIL ramp cycle %0d: got %b expected %b", c, obs, exp_v);
            else n_pass++;
            if (c == 6) begin
                n_checks++;
                if (bus.motor_in !== 4'b0000) $display("FAIL ramp_latency_early: got %b expected 0000", bus.motor_in);
                else n_pass++;
            end
            if (c == 7) begin
                n_checks++;
                if (bus.motor_in !== 4'b1010) $display("FAIL ramp_latency: got %b expected 1010", bus.motor_in);
                else n_pass++;
            end
        end
        hi_a = 0; hi_b = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            hi_a += int'(bus.en_a);
            hi_b += int'(bus.en_b);
        end
        n_checks++;
        if (hi_a != MAX_DUTY || hi_b != MAX_DUTY)
            $display("FAIL ramp_full_duty: got a=%0d b=%0d expected %0d", hi_a, hi_b, MAX_DUTY);
        else n_pass++;
        $display("test_ramp: full-duty highs a=%0d b=%0d", hi_a, hi_b);
    endtask

    task automatic test_glitch();
        bit pins_moved;
        int hi_a;
        pins_moved = 1'b0;
        hi_a = 0;
        for (int c = 0; c < 40; c++) begin
            bus.ctrl_signals = (c < 3) ? 4'b0000 : 4'b1010;
            @(negedge clk);
            obs = {bus.motor_in, bus.en_a, bus.en_b, bus.dead_active};
            exp_v = model_outputs();
            n_checks++;
            if (obs !== exp_v) $display("FAIL glitch cycle %0d: got %b expected %b", c, obs, exp_v);
            else n_pass++;
            if (bus.motor_in !== 4'b1010) pins_moved = 1'b1;
            if (c >= 40 - PERIOD) hi_a += int'(bus.en_a);
        end
        n_checks++;
        if (pins_moved || hi_a != MAX_DUTY)
            $display("FAIL glitch_ignored: got moved=%0d duty=%0d expected moved=0 duty=%0d", pins_moved, hi_a, MAX_DUTY);
        else n_pass++;
        $display("test_glitch: pins_moved=%0d duty=%0d", pins_moved, hi_a);
    endtask

    task automatic test_reversal();
        int dead_cnt;
        bit right_moved, direct_flip;
        logic [1:0] prev_left;
        dead_cnt = 0; right_moved = 1'b0; direct_flip = 1'b0;
        prev_left = bus.motor_in[3:2];
        bus.ctrl_signals = 4'b0110;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            obs = {bus.motor_in, bus.en_a, bus.en_b, bus.dead_active};
            exp_v = model_outputs();
            n_checks++;
            if (obs !== exp_v) $display("FAIL reversal cycle %0d: got %b expected %b", c, obs, exp_v);
            else n_pass++;
            if (bus.dead_active == 2'b10) dead_cnt++;
            if (bus.motor_in[1:0] !== 2'b10) right_moved = 1'b1;
            if ((prev_left ^ bus.motor_in[3:2]) == 2'b11) direct_flip = 1'b1;
            prev_left = bus.motor_in[3:2];
        end
        n_checks++;
        if (dead_cnt != DEAD_CYCLES) $display("FAIL reversal_dead_len: got %0d expected %0d", dead_cnt, DEAD_CYCLES);
        else n_pass++;
        n_checks++;
        if (right_moved || direct_flip || bus.motor_in !== 4'b0110)
            $display("FAIL reversal_pins: got right_moved=%0d flip=%0d pins=%b expected 0 0 0110", right_moved, direct_flip, bus.motor_in);
        else n_pass++;
        $display("test_reversal: dead cycles=%0d", dead_cnt);
    endtask

    task automatic test_brake();
        bit dead_seen;
        dead_seen = 1'b0;
        bus.ctrl_signals = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            obs = {bus.motor_in, bus.en_a, bus.en_b, bus.dead_active};
            exp_v = model_outputs();
            n_checks++;
            if (obs !== exp_v) $display("FAIL brake cycle %0d: got %b expected %b", c, obs, exp_v);
            else n_pass++;
        end
        n_checks++;
        if ({bus.motor_in, bus.en_a, bus.en_b} !== 6'b111111)
            $display("FAIL brake_outputs: got %b expected 111111", {bus.motor_in, bus.en_a, bus.en_b});
        else n_pass++;
        bus.ctrl_signals = 4'b1010;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            obs = {bus.motor_in, bus.en_a, bus.en_b, bus.dead_active};
            exp_v = model_outputs();
            n_checks++;
            if (obs !== exp_v) $display("FAIL brake_release cycle %0d: got %b expected %b", c, obs, exp_v);
            else n_pass++;
            if (bus.dead_active != 2'b00) dead_seen = 1'b1;
        end
        n_checks++;
        if (dead_seen || bus.motor_in !== 4'b1010)
            $display("FAIL brake_to_run: got dead_seen=%0d pins=%b expected 0 1010", dead_seen, bus.motor_in);
        else n_pass++;
        $display("test_brake: released to pins=%b", bus.motor_in);
    endtask

    task automatic test_dead_abort();
        int w;
        bit dead_seen;
        dead_seen = 1'b0;
        bus.ctrl_signals = 4'b0110;
        for (w = 0; w < 50 && bus.dead_active[1] !== 1'b1; w++) begin
            @(negedge clk);
            obs = {bus.motor_in, bus.en_a, bus.en_b, bus.dead_active};
            exp_v = model_outputs();
            n_checks++;
            if (obs !== exp_v) $display("FAIL abort_wait cycle %0d: got %b expected %b", w, obs, exp_v);
            else n_pass++;
        end
        n_checks++;
        if (bus.dead_active[1] !== 1'b1) $display("FAIL abort_dead_entry: got %b expected 1 within 50 cycles", bus.dead_active[1]);
        else n_pass++;
        for (int c = 0; c < 29; c++) begin
            if (c == 9) bus.ctrl_signals = 4'b0000;
            @(negedge clk);
            obs = {bus.motor_in, bus.en_a, bus.en_b, bus.dead_active};
            exp_v = model_outputs();
            n_checks++;
            if (obs !== exp_v) $display("FAIL abort cycle %0d: got %b expected %b", c, obs, exp_v);
            else n_pass++;
        end
        n_checks++;
        if ({bus.motor_in, bus.dead_active} !== 6'b000000)
            $display("FAIL abort_coast: got %b expected 000000", {bus.motor_in, bus.dead_active});
        else n_pass++;
        bus.ctrl_signals = 4'b0101;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            obs = {bus.motor_in, bus.en_a, bus.en_b, bus.dead_active};
            exp_v = model_outputs();
            n_checks++;
            if (obs !== exp_v) $display("FAIL abort_reverse cycle %0d: got %b expected %b", c, obs, exp_v);
            else n_pass++;
            if (bus.dead_active != 2'b00) dead_seen = 1'b1;
        end
        n_checks++;
        if (dead_seen || bus.motor_in !== 4'b0101)
            $display("FAIL abort_then_reverse: got dead_seen=%0d pins=%b expected 0 0101", dead_seen, bus.motor_in);
        else n_pass++;
        $display("test_dead_abort: pins=%b", bus.motor_in);
    endtask

    task automatic test_reset_mid();
        int w;
        bit en_early;
        en_early = 1'b0;
        bus.ctrl_signals = 4'b0000;
        repeat (20) @(negedge clk);
        bus.ctrl_signals = 4'b1010;
        for (w = 0; w < 400 && m_duty[1] != 7; w++) begin
            @(negedge clk);
            obs = {bus.motor_in, bus.en_a, bus.en_b, bus.dead_active};
            exp_v = model_outputs();
            n_checks++;
            if (obs !== exp_v) $display("FAIL midreset_ramp cycle %0d: got %b expected %b", w, obs, exp_v);
            else n_pass++;
        end
        n_checks++;
        if (m_duty[1] != 7) $display("FAIL midreset_reach_duty: got %0d expected 7 within 400 cycles", m_duty[1]);
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        obs = {bus.motor_in, bus.en_a, bus.en_b, bus.dead_active};
        n_checks++;
        if (obs !== 8'h00) $display("FAIL midreset_outputs: got %b expected %b", obs, 8'h00);
        else n_pass++;
        reset = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            obs = {bus.motor_in, bus.en_a, bus.en_b, bus.dead_active};
            exp_v = model_outputs();
            n_checks++;
            if (obs !== exp_v) $display("FAIL midreset_restart cycle %0d: got %b expected %b", c, obs, exp_v);
            else n_pass++;
            if (c == 6) begin
                n_checks++;
                if (bus.motor_in !== 4'b0000) $display("FAIL midreset_latency_early: got %b expected 0000", bus.motor_in);
                else n_pass++;
            end
            if (c == 7) begin
                n_checks++;
                if (bus.motor_in !== 4'b1010) $display("FAIL midreset_latency: got %b expected 1010", bus.motor_in);
                else n_pass++;
            end
            if (c >= 8 && c <= 16 && (bus.en_a || bus.en_b)) en_early = 1'b1;
        end
        n_checks++;
        if (en_early) $display("FAIL midreset_duty_zero: got enable high expected low before first wrap");
        else n_pass++;
        $display("test_reset_mid: restarted pins=%b", bus.motor_in);
    endtask

    task automatic test_random();
        int hold;
        logic [3:0] v;
        logic [3:0] prev_pins;
        prev_pins = bus.motor_in;
        for (int t = 0; t < 60; t++) begin
            v = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 40);
            bus.ctrl_signals = v;
            $display("rand txn %0d: ctrl=%b hold=%0d", t, v, hold);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                obs = {bus.motor_in, bus.en_a, bus.en_b, bus.dead_active};
                exp_v = model_outputs();
                n_checks++;
                if (obs !== exp_v) $display("FAIL random txn %0d cycle %0d: got %b expected %b", t, c, obs, exp_v);
                else n_pass++;
                n_checks++;
                if ((prev_pins[3:2] ^ bus.motor_in[3:2]) == 2'b11 && prev_pins[3:2] != 2'b11 && bus.motor_in[3:2] != 2'b11 ||
                    (prev_pins[1:0] ^ bus.motor_in[1:0]) == 2'b11 && prev_pins[1:0] != 2'b11 && bus.motor_in[1:0] != 2'b11)
                    $display("FAIL random_direct_flip txn %0d: got %b after %b expected a coast gap", t, bus.motor_in, prev_pins);
                else n_pass++;
                prev_pins = bus.motor_in;
            end
        end
    endtask

    initial begin
        bus.ctrl_signals = 4'b0000;
        @(negedge clk);
        test_reset();
        test_ramp();
        test_glitch();
        test_reversal();
        test_brake();
        test_dead_abort();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
